// File: rtl/ayatsuki_dmem.sv
// Byte-addressed big-endian data memory with a one-entry posted-write buffer,
// per-byte read forwarding from that buffer, and sticky/saturating range-error tracking.
module ayatsuki_dmem #(
  parameter int DEPTH_BYTES = 2048,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_enable_i,
  input  logic                 mem_w_enable_i,
  input  logic                 mem_r_enable_i,
  input  logic [31:0]          mem_w_addr_i,
  input  logic [31:0]          mem_r_addr_i,
  input  logic [31:0]          mem_data_i,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          dbg_addr_i,
  output logic [7:0]           dbg_data_o,
  output logic                 wbuf_busy_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int          AW       = $clog2(DEPTH_BYTES);
  localparam logic [31:0] MAX_ADDR = 32'(DEPTH_BYTES - 4);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH_BYTES);

  logic [7:0] mem_q [DEPTH_BYTES];

  logic                 wbuf_vld_q, wbuf_vld_d;
  logic [AW-1:0]        wbuf_addr_q, wbuf_addr_d;
  logic [31:0]          wbuf_dat_q, wbuf_dat_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic acc_en, wr_req, rd_req, wr_in, rd_in, wr_ok, rd_ok, oor;

  // Accesses presented while reset is held are ignored entirely.
  assign acc_en = mem_enable_i & ~rst;
  assign wr_req = acc_en & mem_w_enable_i;
  assign rd_req = acc_en & mem_r_enable_i;
  assign wr_in  = (mem_w_addr_i <= MAX_ADDR);
  assign rd_in  = (mem_r_addr_i <= MAX_ADDR);
  assign wr_ok  = wr_req & wr_in;
  assign rd_ok  = rd_req & rd_in;
  assign oor    = (wr_req & ~wr_in) | (rd_req & ~rd_in);

  always_comb begin
    wbuf_vld_d  = wr_ok;
    wbuf_addr_d = wbuf_addr_q;
    wbuf_dat_d  = wbuf_dat_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    if (wr_ok) begin
      wbuf_addr_d = mem_w_addr_i[AW-1:0];
      wbuf_dat_d  = mem_data_i;
    end
    if (oor) begin
      err_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_vld_q  <= 1'b0;
      wbuf_addr_q <= '0;
      wbuf_dat_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      wbuf_vld_q  <= wbuf_vld_d;
      wbuf_addr_q <= wbuf_addr_d;
      wbuf_dat_q  <= wbuf_dat_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Reset clears the buffer valid asynchronously, so a pending entry is never committed.
  always_ff @(posedge clk) begin
    if (wbuf_vld_q) begin
      for (int k = 0; k < 4; k++) begin
        mem_q[wbuf_addr_q + AW'(k)] <= wbuf_dat_q[31-8*k -: 8];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [AW-1:0] rd_byte_addr;
    logic [AW-1:0] rd_diff;
    logic [31:0]   wbuf_shift;
    logic          fwd_hit;
    logic [7:0]    lane_byte;

    // Both addresses are in range, so a modular difference below 4 means the byte is buffered.
    assign rd_byte_addr = mem_r_addr_i[AW-1:0] + AW'(g);
    assign rd_diff      = rd_byte_addr - wbuf_addr_q;
    assign wbuf_shift   = wbuf_dat_q << {rd_diff[1:0], 3'b000};
    assign fwd_hit      = wbuf_vld_q & (rd_diff < AW'(4));
    assign lane_byte    = fwd_hit ? wbuf_shift[31:24] : mem_q[rd_byte_addr];
    assign mem_data_o[31-8*g -: 8] = rd_ok ? lane_byte : 8'h00;
  end

  assign dbg_data_o  = (dbg_addr_i < DEPTH_W) ? mem_q[dbg_addr_i[AW-1:0]] : 8'h00;
  assign wbuf_busy_o = wbuf_vld_q;
  assign err_o       = err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
